// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle MIPS controller and its
// datapath + wait-stated memory. master = controller side, slave = datapath side.
interface multicycle_controller_if #(
  parameter int ALUOP_W = 5,
  parameter int BJ_W    = 3
);
  logic [5:0]         Opcode;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               IRWrite;
  logic               RegDst;
  logic               ALUSource;
  logic               MemToReg;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic [BJ_W-1:0]    BranchJump;
  logic [ALUOP_W-1:0] ALUOp;
  logic [2:0]         State;
  logic               Error;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, IRWrite, RegDst, ALUSource, MemToReg,
           RegWrite, MemRead, MemWrite, BranchJump, ALUOp, State, Error
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, IRWrite, RegDst, ALUSource, MemToReg,
           RegWrite, MemRead, MemWrite, BranchJump, ALUOp, State, Error
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait timeout.
// Define CTRL_TRAP_EN to trap (and hold) on illegal opcodes and memory timeouts.
module multicycle_controller #(
  parameter int ALUOP_W    = 5,
  parameter int BJ_W       = 3,
  parameter int WAIT_LIMIT = 15
) (
  input logic                  Clk,
  input logic                  Reset_n,
  multicycle_controller_if.master bus
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
`ifdef CTRL_TRAP_EN
  localparam int SW = 4;
`else
  localparam int SW = 3;
`endif

  typedef enum logic [SW-1:0] {
    S_IDLE   = SW'(0),
    S_FETCH  = SW'(1),
    S_DECODE = SW'(2),
    S_EXEC   = SW'(3),
    S_MEM    = SW'(4),
    S_WB     = SW'(5),
    S_BRANCH = SW'(6),
    S_JUMP   = SW'(7)
`ifdef CTRL_TRAP_EN
    , S_TRAP = SW'(8)
`endif
  } state_t;

  localparam logic [3:0] ALU_R    = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_ADDU = 4'd7;
  localparam logic [3:0] ALU_SP2  = 4'd8;
  localparam logic [3:0] ALU_SP3  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd11;

  localparam logic [2:0] BJ_NONE   = 3'd0;
  localparam logic [2:0] BJ_BEQ    = 3'd1;
  localparam logic [2:0] BJ_BNE    = 3'd2;
  localparam logic [2:0] BJ_J      = 3'd3;
  localparam logic [2:0] BJ_REGIMM = 3'd4;
  localparam logic [2:0] BJ_BGTZ   = 3'd5;
  localparam logic [2:0] BJ_BLEZ   = 3'd6;
  localparam logic [2:0] BJ_JAL    = 3'd7;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h1C) || (op == 6'h1F);
  endfunction

  function automatic logic is_alu(input logic [5:0] op);
    return is_rtype(op) || ((op >= 6'h08) && (op <= 6'h0F));
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == 6'h01) || ((op >= 6'h04) && (op <= 6'h07));
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return (op == 6'h02) || (op == 6'h03);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [5:0] op);
    logic [3:0] r;
    case (op)
      6'h00:   r = ALU_R;
      6'h09:   r = ALU_ADDU;
      6'h0A:   r = ALU_SLT;
      6'h0B:   r = ALU_SLTU;
      6'h0C:   r = ALU_AND;
      6'h0D:   r = ALU_OR;
      6'h0E:   r = ALU_XOR;
      6'h1C:   r = ALU_SP2;
      6'h1F:   r = ALU_SP3;
      default: r = ALU_ADD;  // addi, lui and load/store address generation
    endcase
    return r;
  endfunction

  function automatic logic [2:0] bj_sel(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      6'h01:   r = BJ_REGIMM;
      6'h04:   r = BJ_BEQ;
      6'h05:   r = BJ_BNE;
      6'h06:   r = BJ_BLEZ;
      6'h07:   r = BJ_BGTZ;
      default: r = BJ_NONE;
    endcase
    return r;
  endfunction

  state_t        state, next_state;
  logic [5:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          err;
  logic          access;
  logic          timeout;
  logic          err_set;

  assign access  = (state == S_FETCH) || (state == S_MEM);
  assign timeout = access && !bus.MemReady && (wait_cnt == CW'(WAIT_LIMIT));

`ifdef CTRL_TRAP_EN
  logic illegal;
  assign illegal = (state == S_DECODE) &&
                   !(is_alu(bus.Opcode) || is_load(bus.Opcode) || is_store(bus.Opcode) ||
                     is_branch(bus.Opcode) || is_jump(bus.Opcode));
  assign err_set = timeout || illegal;
`else
  assign err_set = timeout;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= bus.Opcode;
      // Counter only runs while an access is outstanding; any completion,
      // timeout or state change leaves it cleared for the next access.
      if (access && !bus.MemReady && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                     wait_cnt <= '0;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (bus.MemReady) next_state = S_DECODE;
`ifdef CTRL_TRAP_EN
        else if (timeout) next_state = S_TRAP;
`endif
      end
      S_DECODE: begin
        if (is_alu(bus.Opcode) || is_load(bus.Opcode) || is_store(bus.Opcode))
          next_state = S_EXEC;
        else if (is_branch(bus.Opcode))
          next_state = S_BRANCH;
        else if (is_jump(bus.Opcode))
          next_state = S_JUMP;
        else
`ifdef CTRL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
`endif
      end
      S_EXEC: next_state = (is_load(op_q) || is_store(op_q)) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.MemReady)
          next_state = is_load(op_q) ? S_WB : S_FETCH;
        else if (timeout)
`ifdef CTRL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
`endif
      end
      S_WB:     next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = state;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSource   = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.BranchJump  = '0;
    bus.ALUOp       = '0;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUOp   = ALUOP_W'(ALU_ADD);
        // IR/PC load qualified by MemReady so a timed-out fetch leaves PC alone.
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_EXEC: begin
        bus.ALUOp     = ALUOP_W'(alu_sel(op_q));
        bus.ALUSource = !is_rtype(op_q);
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = is_load(op_q);
        bus.MemWrite = is_store(op_q);
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = !is_load(op_q);
        bus.RegDst   = !is_rtype(op_q);
      end
      S_BRANCH: begin
        bus.ALUOp       = ALUOP_W'(ALU_SUB);
        bus.BranchJump  = BJ_W'(bj_sel(op_q));
        bus.PCWriteCond = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.BranchJump = (op_q == 6'h03) ? BJ_W'(BJ_JAL) : BJ_W'(BJ_J);
        bus.RegWrite   = (op_q == 6'h03);
      end
      default: ;
    endcase
  end

`ifdef CTRL_TRAP_EN
  assign bus.State = (state == S_TRAP) ? 3'd0 : state[2:0];
`else
  assign bus.State = state;
`endif
  assign bus.Error = err;

endmodule
